// File: rtl/sub_serial_32bit.sv
// Digit-serial two's-complement subtractor: A - B computed as A + ~B + 1, one DIGIT slice per clock.
// Produces carry/no-borrow, signed overflow, signed less-than and not-equal flags.
module sub_serial_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             carry_out,
  output logic             overflow,
  output logic             isLessThan,
  output logic             isNotEqual
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, nb_q, result_q, result_d;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             carry_out_q, overflow_q, lt_q, ne_q;
  logic [DIGIT:0]   slice_sum;
  logic [31:0]      base;
  logic             ovf_d;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One ripple slice; nb_q already holds ~B and carry_q starts at 1 for the +1.
  always_comb begin
    base      = 32'(cnt_q) * DIGIT;
    slice_sum = {1'b0, a_q[base +: DIGIT]} + {1'b0, nb_q[base +: DIGIT]}
              + {{DIGIT{1'b0}}, carry_q};
    result_d  = result_q;
    result_d[base +: DIGIT] = slice_sum[DIGIT-1:0];
    // Operand signs differ exactly when A's sign equals ~B's sign.
    ovf_d     = (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      a_q         <= '0;
      nb_q        <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      lt_q        <= 1'b0;
      ne_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && in_valid) begin
        a_q      <= data_operandA;
        nb_q     <= ~data_operandB;
        carry_q  <= 1'b1;
        cnt_q    <= '0;
        result_q <= '0;
      end else if (state_q == StRun) begin
        result_q <= result_d;
        carry_q  <= slice_sum[DIGIT];
        cnt_q    <= cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          carry_out_q <= slice_sum[DIGIT];
          overflow_q  <= ovf_d;
          lt_q        <= result_d[WIDTH-1] ^ ovf_d;
          ne_q        <= |result_d;
        end
      end
    end
  end

  assign data_result = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;
  assign isLessThan  = lt_q;
  assign isNotEqual  = ne_q;

endmodule

// File: tb/tb_sub_serial_32bit.sv
// Directed bench for sub_serial_32bit: flags, latency, backpressure, mid-run reset and back-to-back ops.
module tb_sub_serial_32bit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;
  logic        carry_out;
  logic        overflow;
  logic        isLessThan;
  logic        isNotEqual;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sub_serial_32bit dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_result   (data_result),
    .carry_out     (carry_out),
    .overflow      (overflow),
    .isLessThan    (isLessThan),
    .isNotEqual    (isNotEqual)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] r, input logic c,
                            input logic ov, input logic lt, input logic ne);
    check({tag, "_result"}, data_result, r);
    check({tag, "_carry"}, {31'b0, carry_out}, {31'b0, c});
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ov});
    check({tag, "_lt"}, {31'b0, isLessThan}, {31'b0, lt});
    check({tag, "_ne"}, {31'b0, isNotEqual}, {31'b0, ne});
  endtask

  // Accept one op, measure latency to out_valid, check outputs; leaves the DUT in DONE.
  task automatic start_and_wait(input string tag, input logic [31:0] a, input logic [31:0] b);
    int k;
    @(negedge clock);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(posedge clock);
      #1;
      k++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, k, 32'd8);
  endtask

  task automatic handoff(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  logic [31:0] b2b_a [3];
  logic [31:0] b2b_b [3];
  logic [31:0] b2b_r [3];
  int          acc   [3];
  int          waited;
  int          seen_valid;

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_outs("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    start_and_wait("sub5_3", 32'd5, 32'd3);
    check_outs("sub5_3", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
    handoff("sub5_3");

    start_and_wait("sub0_1", 32'd0, 32'd1);
    check_outs("sub0_1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    handoff("sub0_1");

    start_and_wait("minneg", 32'h8000_0000, 32'd1);
    check_outs("minneg", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    handoff("minneg");

    start_and_wait("maxpos", 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check_outs("maxpos", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    handoff("maxpos");

    // Equal operands, then backpressure with a competing request that must be ignored.
    start_and_wait("equal", 32'h1234_5678, 32'h1234_5678);
    check_outs("equal", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    in_valid      = 1'b1;
    data_operandA = 32'hAAAA_0000;
    data_operandB = 32'h0000_5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check_outs("bp", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    handoff("equal");
    check_outs("post_handoff", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset four edges into RUN discards the partial result.
    @(negedge clock);
    in_valid      = 1'b1;
    data_operandA = 32'h0000_FFFF;
    data_operandB = 32'd1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check_outs("midrst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset      = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen_valid++;
    end
    check("midrst_no_valid", seen_valid, 32'd0);

    start_and_wait("sub10_20", 32'd10, 32'd20);
    check_outs("sub10_20", 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b1, 1'b1);
    handoff("sub10_20");

    // Back-to-back with in_valid and out_ready held high.
    b2b_a[0] = 32'd100;        b2b_b[0] = 32'd1;          b2b_r[0] = 32'd99;
    b2b_a[1] = 32'd1;          b2b_b[1] = 32'd2;          b2b_r[1] = 32'hFFFF_FFFF;
    b2b_a[2] = 32'hDEAD_BEEF;  b2b_b[2] = 32'h0EAD_BEEF;  b2b_r[2] = 32'hD000_0000;
    @(negedge clock);
    out_ready     = 1'b1;
    in_valid      = 1'b1;
    data_operandA = b2b_a[0];
    data_operandB = b2b_b[0];
    for (int i = 0; i < 3; i++) begin
      waited = 0;
      while (!in_ready && waited < 30) begin
        @(negedge clock);
        waited++;
      end
      check("b2b_accept_timeout", {31'b0, waited < 30}, 32'd1);
      acc[i] = cyc;
      @(posedge clock);
      #1;
      if (i < 2) begin
        data_operandA = b2b_a[i+1];
        data_operandB = b2b_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
      waited = 0;
      while (!out_valid && waited < 30) begin
        @(negedge clock);
        waited++;
      end
      check("b2b_done_timeout", {31'b0, waited < 30}, 32'd1);
      check("b2b_result", data_result, b2b_r[i]);
    end
    check("b2b_spacing1", acc[1] - acc[0], 32'd10);
    check("b2b_spacing2", acc[2] - acc[1], 32'd10);
    @(negedge clock);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_serial_32bit.md
Name: sub_serial_32bit

Overview:
- Multi-cycle two's-complement subtractor computing data_operandA − data_operandB as A + ~B + 1.
- Processes one DIGIT-bit slice per clock, with the carry held in a register between slices.
- Produces the ALU comparison flags (isNotEqual, isLessThan, overflow) and unsigned carry/no-borrow.
- Area-cheap alternative to the combinational 32-bit lookahead adder, used by the multicycle datapath and for compare/branch evaluation. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; NSLICE = WIDTH/DIGIT (8 at default).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- data_operandA  input  WIDTH  minuend.
- data_operandB  input  WIDTH  subtrahend.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- data_result  output  WIDTH  A − B, modulo 2^WIDTH.
- carry_out  output  1  final carry; 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow.
- isLessThan  output  1  A < B, signed.
- isNotEqual  output  1  A != B.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, on port reset. Clock port is clock.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - data_result, carry_out, overflow, isLessThan, isNotEqual = 0.
  - Internal operand registers, slice counter and carry register = 0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready = 1. On an edge with in_valid = 1:
    - latch A, latch ~B;
    - carry register = 1, slice counter = 0;
    - clear data_result;
    - go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each edge:
    - {c, data_result[k*DIGIT +: DIGIT]} = A_slice + ~B_slice + c, where k = slice counter;
    - counter increments;
    - on k = NSLICE−1 (the final slice), go to DONE and register the flags.
  - DONE: out_valid = 1, in_ready = 0. All outputs held stable until an edge with out_ready = 1, which moves to IDLE.
- Flags use the final result R:
  - carry_out = final c.
  - overflow = (A[W−1] != B[W−1]) && (R[W−1] != A[W−1]).
  - isLessThan = R[W−1] XOR overflow.
  - isNotEqual = |R.
- Latency:
  - Acceptance edge is t0. out_valid rises after edge t0+NSLICE (8 cycles at default).
  - Throughput is one op per NSLICE+2 cycles when out_ready is held high: the DONE→IDLE edge plus the IDLE accept edge.
- Boundaries:
  - Operand inputs and in_valid are ignored outside IDLE and never corrupt an operation in flight.
  - No accept in the same cycle as DONE→IDLE; in_ready is low in DONE.
  - Outputs stay stable in DONE under out_ready = 0 for any number of cycles (backpressure).
  - In IDLE after a handoff, out_valid = 0. data_result and flags keep their last values until the next accept clears data_result.
  - Reset asserted mid-RUN or in DONE: immediate return to IDLE with all reset values. The partial result is discarded and no out_valid pulse is produced.
  - Arithmetic wraps modulo 2^WIDTH. The carry out of the top slice goes only to carry_out.

Test Plan:
- A=5, B=3 -> after 8 cycles: result 0x00000002, carry_out 1, overflow 0, isLessThan 0, isNotEqual 1.
- A=0, B=1 -> result 0xFFFFFFFF, carry_out 0, overflow 0, isLessThan 1, isNotEqual 1.
- A=0x80000000, B=1 -> result 0x7FFFFFFF, overflow 1, isLessThan 1, carry_out 1. A=0x7FFFFFFF, B=0xFFFFFFFF -> result 0x80000000, overflow 1, isLessThan 0.
- A=B=0x12345678 -> result 0, isNotEqual 0, isLessThan 0, carry_out 1. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready stays 0; new in_valid with other operands is ignored.
- Reset pulsed at RUN cycle 4 -> next cycle in IDLE, all outputs 0, no out_valid. A fresh op with A=10, B=20 -> result 0xFFFFFFF6, isLessThan 1.
- Back-to-back: in_valid held high and out_ready high for 3 ops -> accepts spaced 10 cycles apart, correct results each time.
